register_read_port: RTL and testbench
=====================================

REGISTER_READ_PORT -- requirements
Module: register_read_port

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of registers and responses.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of response buffer entries; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  a read request is presented.
REQ-007 req_ready  output  1  the block can accept a request this cycle.
REQ-008 rs_a  input  3  source address A: 000..110 = gpr1..gpr7, 111 = ir.
REQ-009 rs_b  input  3  source address B, with the same encoding as rs_a.
REQ-010 gpr1..gpr7, ir  input  WIDTH each  current register file contents.
REQ-011 wr_en  input  1  the register file write port is writing this cycle.
REQ-012 wr_addr  input  3  write port address, with the same encoding as rs_a.
REQ-013 wr_data  input  WIDTH  write port data.
REQ-014 rsp_valid  output  1  the head response is valid.
REQ-015 rsp_ready  input  1  the consumer accepts the head response.
REQ-016 rsp_a, rsp_b  output  WIDTH each  operand values for the head response.

Function
REQ-017 A request SHALL be accepted in a cycle when req_valid and req_ready are both 1 at the rising edge.
REQ-018 A response SHALL be popped in a cycle when rsp_valid and rsp_ready are both 1 at the rising edge.
REQ-019 On accept, the block SHALL select the operand for each of rs_a and rs_b by address, using the REQ-008 encoding.
REQ-020 Bypass: if wr_en is 1 and wr_addr equals the source address in the accept cycle, that operand SHALL be wr_data instead of the register value.
REQ-021 Bypass SHALL be applied independently to A and B; both operands take wr_data when rs_a = rs_b = wr_addr.
REQ-022 The selected pair SHALL be written into a DEPTH-entry FIFO; responses are delivered in acceptance order.
REQ-023 Latency: a request accepted at edge N into an empty FIFO SHALL present rsp_valid = 1 with its data after edge N; there is no combinational path from request to response.
REQ-024 Occupancy count runs 0..DEPTH; req_ready SHALL be 1 exactly when count < DEPTH, and rsp_valid SHALL be 1 exactly when count > 0.
REQ-025 Accept without pop SHALL increment count; pop without accept SHALL decrement count; accept and pop together SHALL leave count unchanged and write one entry while reading another.
REQ-026 Full: with count = DEPTH, req_ready is 0; req_valid SHALL be ignored and the FIFO contents SHALL NOT change.
REQ-027 Empty: with count = 0, rsp_ready SHALL be ignored and count SHALL NOT underflow.
REQ-028 Read and write pointers are log2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-029 rsp_a and rsp_b SHALL hold stable while rsp_valid = 1 and rsp_ready = 0.
REQ-030 Register inputs that change after acceptance SHALL NOT affect buffered responses; the snapshot is taken at the accept edge.
REQ-031 The block is read-only and SHALL NOT drive any register file input.

Reset
REQ-032 When rst = 1 at a rising edge, count and both pointers SHALL clear to 0.
REQ-033 After that reset edge, rsp_valid SHALL be 0, req_ready SHALL be 1, and rsp_a = rsp_b = 0.
REQ-034 Reset SHALL take priority over a simultaneous accept or pop; in-flight and buffered responses are discarded.
REQ-035 FIFO storage need not be cleared, but its contents SHALL NOT be visible while rsp_valid = 0 (outputs forced to 0).

Verification
REQ-036 Basic read: gpr3 = 16'h1234, ir = 16'hBEEF, rs_a = 010, rs_b = 111, accepted at edge N -> after edge N, rsp_valid = 1, rsp_a = 16'h1234, rsp_b = 16'hBEEF.
REQ-037 Bypass: gpr5 = 16'h0001, wr_en = 1, wr_addr = 100, wr_data = 16'h00AA, rs_a = rs_b = 100 in the accept cycle -> rsp_a = rsp_b = 16'h00AA; repeat with wr_en = 0 -> both 16'h0001.
REQ-038 Backpressure/full (DEPTH = 2): rsp_ready = 0, three back-to-back requests reading gpr1 = 16'h0011, gpr2 = 16'h0022, gpr3 = 16'h0033 -> req_ready = 0 after the second accept; third request is held off; draining returns 16'h0011, then 16'h0022, then the third after acceptance.
REQ-039 Simultaneous accept and pop at count = 1 with continuous req_valid and rsp_ready for 8 cycles -> one response per cycle, count stays 1, pointers wrap, order preserved.
REQ-040 Snapshot: accept a read of gpr7 = 16'h7777, then change gpr7 to 16'h8888 while rsp_ready = 0 -> rsp_a stays 16'h7777 until popped.
REQ-041 Reset mid-operation: FIFO full, assert rst for one edge -> rsp_valid = 0, req_ready = 1, outputs 0; the next request reads fresh values with 1-cycle latency.

Source files
------------

// File: rtl/register_read_port.sv
// register_read_port: captures a pair of register-file operands on request
// acceptance (with write-port bypass) and queues them in a small FIFO so the
// consumer can apply backpressure without losing the snapshot.
module register_read_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       rs_a,
  input  logic [2:0]       rs_b,
  input  logic [WIDTH-1:0] gpr1,
  input  logic [WIDTH-1:0] gpr2,
  input  logic [WIDTH-1:0] gpr3,
  input  logic [WIDTH-1:0] gpr4,
  input  logic [WIDTH-1:0] gpr5,
  input  logic [WIDTH-1:0] gpr6,
  input  logic [WIDTH-1:0] gpr7,
  input  logic [WIDTH-1:0] ir,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_a,
  output logic [WIDTH-1:0] rsp_b
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Address-indexed view of the register file: 0..6 = gpr1..gpr7, 7 = ir.
  logic [WIDTH-1:0] reg_view [8];
  assign reg_view[0] = gpr1;
  assign reg_view[1] = gpr2;
  assign reg_view[2] = gpr3;
  assign reg_view[3] = gpr4;
  assign reg_view[4] = gpr5;
  assign reg_view[5] = gpr6;
  assign reg_view[6] = gpr7;
  assign reg_view[7] = ir;

  // Operand 0 is A, operand 1 is B; each gets its own bypass comparator.
  logic [2:0]       src_addr [2];
  logic [WIDTH-1:0] operand  [2];
  assign src_addr[0] = rs_a;
  assign src_addr[1] = rs_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign operand[gi] = (wr_en && (wr_addr == src_addr[gi])) ? wr_data
                                                                 : reg_view[src_addr[gi]];
    end
  endgenerate

  // FIFO storage and bookkeeping.
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop;

  assign req_ready = (count_reg < CNT_W'(DEPTH));
  assign rsp_valid = (count_reg != '0);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Stored entries are hidden behind zeros whenever the FIFO is empty.
  assign rsp_a = rsp_valid ? mem_a[rd_ptr_reg] : '0;
  assign rsp_b = rsp_valid ? mem_b[rd_ptr_reg] : '0;

  // Next pointer/count values; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Snapshot the selected operands at the accept edge; storage is never cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_reg] <= operand[0];
      mem_b[wr_ptr_reg] <= operand[1];
    end
  end

endmodule

// File: tb/tb_register_read_port.sv
// tb_register_read_port: scoreboard bench for register_read_port (DEPTH = 2).
module tb_register_read_port;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       rs_a, rs_b;
  logic [WIDTH-1:0] g [8];
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_a, rsp_b;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_rsp        = 0;
  int model_cnt    = 0;
  logic [31:0] sb [$];

  register_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .rs_a(rs_a), .rs_b(rs_b),
    .gpr1(g[0]), .gpr2(g[1]), .gpr3(g[2]), .gpr4(g[3]),
    .gpr5(g[4]), .gpr6(g[5]), .gpr7(g[6]), .ir(g[7]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected operand for one source address, including write-port bypass.
  function automatic logic [WIDTH-1:0] exp_op(input logic [2:0] addr);
    if (wr_en && wr_addr == addr) return wr_data;
    return g[addr];
  endfunction

  // One clock cycle: check outputs against the model, update the scoreboard
  // from the inputs currently driven, then advance to the next falling edge.
  task automatic cycle();
    logic acc, pop;
    logic [31:0] head;
    check_eq("req_ready", {31'b0, req_ready}, {31'b0, model_cnt < DEPTH});
    check_eq("rsp_valid", {31'b0, rsp_valid}, {31'b0, model_cnt > 0});
    if (model_cnt > 0) begin
      head = sb[0];
      check_eq("rsp_a", {16'b0, rsp_a}, {16'b0, head[31:16]});
      check_eq("rsp_b", {16'b0, rsp_b}, {16'b0, head[15:0]});
    end else begin
      check_eq("rsp_a_idle", {16'b0, rsp_a}, 32'h0);
      check_eq("rsp_b_idle", {16'b0, rsp_b}, 32'h0);
    end
    acc = req_valid && (model_cnt < DEPTH);
    pop = rsp_ready && (model_cnt > 0);
    if (rst) begin
      sb.delete();
      $display("reset: buffered responses discarded");
    end else begin
      if (pop) begin
        head = sb.pop_front();
        n_rsp++;
        $display("rsp %0d: a=%h b=%h", n_rsp, head[31:16], head[15:0]);
      end
      if (acc) sb.push_back({exp_op(rs_a), exp_op(rs_b)});
    end
    model_cnt = sb.size();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    rs_a = '0; rs_b = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 8; i++) g[i] = WIDTH'(16'h1000 + i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    cycle();

    // Basic read: A = gpr3, B = ir.
    g[2] = 16'h1234; g[7] = 16'hBEEF; rs_a = 3'b010; rs_b = 3'b111; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    check_eq("basic_valid", {31'b0, rsp_valid}, 32'h1);
    check_eq("basic_a", {16'b0, rsp_a}, 32'h1234);
    check_eq("basic_b", {16'b0, rsp_b}, 32'hBEEF);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;

    // Bypass on both operands, then the same read without a write.
    g[4] = 16'h0001; wr_en = 1'b1; wr_addr = 3'b100; wr_data = 16'h00AA;
    rs_a = 3'b100; rs_b = 3'b100; req_valid = 1'b1;
    cycle();
    check_eq("bypass_a", {16'b0, rsp_a}, 32'h00AA);
    check_eq("bypass_b", {16'b0, rsp_b}, 32'h00AA);
    wr_en = 1'b0; rsp_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    check_eq("nobypass_a", {16'b0, rsp_a}, 32'h0001);
    check_eq("nobypass_b", {16'b0, rsp_b}, 32'h0001);
    cycle();
    rsp_ready = 1'b0;

    // Backpressure until full; third request held off.
    g[0] = 16'h0011; g[1] = 16'h0022; g[2] = 16'h0033; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rs_a = 3'(i); rs_b = 3'(i);
      cycle();
    end
    cycle();
    check_eq("full_ready", {31'b0, req_ready}, 32'h0);
    check_eq("full_head", {16'b0, rsp_a}, 32'h0011);
    rsp_ready = 1'b1;
    cycle();
    check_eq("drain_2nd", {16'b0, rsp_a}, 32'h0022);
    req_valid = 1'b0;
    repeat (3) cycle();
    rsp_ready = 1'b0;

    // Continuous accept+pop at count 1 across pointer wrap.
    req_valid = 1'b1; rs_a = 3'b000; rs_b = 3'b001;
    cycle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rs_a = 3'($urandom_range(0, 7)); rs_b = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) g[k] = WIDTH'($urandom);
      cycle();
      check_eq("stream_count1", {31'b0, rsp_valid & req_ready}, 32'h1);
    end
    req_valid = 1'b0;
    cycle();
    rsp_ready = 1'b0;

    // Snapshot: register changes after acceptance are not seen.
    g[6] = 16'h7777; rs_a = 3'b110; rs_b = 3'b110; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0; g[6] = 16'h8888;
    repeat (3) cycle();
    check_eq("snapshot_a", {16'b0, rsp_a}, 32'h7777);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;

    // Reset while full, then a fresh request.
    req_valid = 1'b1; rs_a = 3'b011; rs_b = 3'b101;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; req_valid = 1'b0;
    check_eq("rst_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("rst_ready", {31'b0, req_ready}, 32'h1);
    check_eq("rst_a", {16'b0, rsp_a}, 32'h0);
    cycle();
    g[3] = 16'h3C3C; g[5] = 16'h5A5A; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    check_eq("post_rst_a", {16'b0, rsp_a}, 32'h3C3C);
    check_eq("post_rst_b", {16'b0, rsp_b}, 32'h5A5A);
    rsp_ready = 1'b1;
    cycle();

    // Random traffic with bypass and backpressure.
    for (int i = 0; i < 200; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      rs_a      = 3'($urandom_range(0, 7));
      rs_b      = 3'($urandom_range(0, 7));
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = WIDTH'($urandom);
      g[$urandom_range(0, 7)] = WIDTH'($urandom);
      cycle();
    end
    req_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
